run_seq: RTL and testbench

- Run sequencer directly upstream of the single-cycle core top level.
- Accepts a start request and streams operand bytes into data memory through a preload write port.
- Holds the core in reset for a fixed number of cycles, releases it, then watches the core's done flag.
- Reports completion, cycle count and timeout to the bench/host; the host never drives the core's reset or data-memory port directly.

---
 rtl/run_pkg.sv | 17 +
 rtl/sat_counter.sv | 40 ++++
 rtl/run_seq.sv | 187 ++++++++++++++++++
 tb/tb_run_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_pkg.sv
// Shared types and constants for the run sequencer.
//   run_state_t : sequencer FSM state encoding (3 bits)
//   RST_CNT_W   : width of the core-reset hold counter
package run_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned RST_CNT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        HOLD   = 3'd2,
        RUN    = 3'd3,
        FINISH = 3'd4
    } run_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (count -> 0)
//   clr_i   : synchronous clear, has priority over en_i
//   en_i    : increment enable; the count sticks at all-ones
//   cnt_o   : registered count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment until saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_seq.sv
// Run sequencer in front of the single-cycle core: preloads data memory from
// a host beat stream, holds the core in reset, runs it until done or timeout
// and reports completion.
//   clk, reset        : clock, synchronous active-high reset
//   req               : start request (sampled in IDLE)
//   ld_valid/ld_ready : preload beat handshake; ld_addr/ld_data/ld_last payload
//   mem_wr_en/mem_addr/mem_dat : registered data-memory preload write
//   core_reset        : core reset, low only while running
//   core_done         : core finished flag
//   busy/ack/timeout/cycles    : status towards the host
module run_seq
    import run_pkg::*;
#(
    parameter int unsigned D       = 10,
    parameter int unsigned AW      = 8,
    parameter int unsigned CW      = 16,
    parameter int unsigned RST_CYC = 2,
    parameter int unsigned TMO     = 32'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic          busy,
    output logic          ack,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    // Elaboration-time parameter sanity
    if (D == 0) begin : g_bad_d
        $error("run_seq: D must be non-zero");
    end
    if ((RST_CYC < 1) || (RST_CYC > 15)) begin : g_bad_rst_cyc
        $error("run_seq: RST_CYC must be in 1..15");
    end
    if (64'(TMO) >= (64'd1 << CW)) begin : g_bad_tmo
        $error("run_seq: TMO must be below 2**CW");
    end

    run_state_t           state_q, state_d;
    logic                 ld_ready_q, ld_ready_d;
    logic                 mem_wr_en_q, mem_wr_en_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [7:0]           mem_dat_q, mem_dat_d;
    logic                 core_reset_q, core_reset_d;
    logic                 busy_q, busy_d;
    logic                 ack_q, ack_d;
    logic                 timeout_q, timeout_d;

    logic                 cyc_clr_c;
    logic                 cyc_en_c;
    logic                 hold_clr_c;
    logic                 hold_en_c;
    logic                 beat_c;
    logic [RST_CNT_W-1:0] hold_cnt;

    // RUN-state cycle counter; doubles as the cycles output
    sat_counter #(
        .W (CW)
    ) u_cyc_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (cyc_clr_c),
        .en_i    (cyc_en_c),
        .cnt_o   (cycles)
    );

    // Core-reset hold counter, parked at zero outside HOLD
    sat_counter #(
        .W (RST_CNT_W)
    ) u_hold_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (hold_clr_c),
        .en_i    (hold_en_c),
        .cnt_o   (hold_cnt)
    );

    assign beat_c     = ld_valid && ld_ready_q;
    assign hold_clr_c = (state_q != HOLD);
    assign hold_en_c  = (state_q == HOLD);

    // Next state, counter controls and registered-output next values
    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        mem_addr_d  = mem_addr_q;
        mem_dat_d   = mem_dat_q;
        mem_wr_en_d = 1'b0;
        cyc_clr_c   = 1'b0;
        cyc_en_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = LOAD;
                    cyc_clr_c = 1'b1;
                    timeout_d = 1'b0;
                end
            end
            LOAD: begin
                if (beat_c) begin
                    mem_wr_en_d = 1'b1;
                    mem_addr_d  = ld_addr;
                    mem_dat_d   = ld_data;
                    if (ld_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == RST_CNT_W'(RST_CYC - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // done has priority over the limit check in the same cycle
                if (core_done) begin
                    state_d = FINISH;
                end else if (cycles == CW'(TMO)) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end else begin
                    cyc_en_c = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are decoded from the upcoming state so they line up
        // with the state register
        ld_ready_d   = (state_d == LOAD);
        busy_d       = (state_d != IDLE);
        core_reset_d = (state_d != RUN);
        ack_d        = (state_d == FINISH);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ld_ready_q   <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_dat_q    <= '0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ld_ready_q   <= ld_ready_d;
            mem_wr_en_q  <= mem_wr_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_dat_q    <= mem_dat_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            timeout_q    <= timeout_d;
        end
    end

    assign ld_ready   = ld_ready_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign mem_addr   = mem_addr_q;
    assign mem_dat    = mem_dat_q;
    assign core_reset = core_reset_q;
    assign busy       = busy_q;
    assign ack        = ack_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_run_seq.sv
// Randomized self-checking bench for run_seq with a transaction-level model:
// expected preload writes are queued per accepted beat, expected run length,
// cycle count and timeout are computed from the chosen done cycle and limit.
module tb_run_seq;

    localparam int unsigned D       = 10;
    localparam int unsigned AW      = 8;
    localparam int unsigned CW      = 16;
    localparam int unsigned RST_CYC = 2;
    localparam int unsigned TMO     = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_dat;
    logic          core_reset;
    logic          core_done;
    logic          busy;
    logic          ack;
    logic          timeout;
    logic [CW-1:0] cycles;

    run_seq #(
        .D       (D),
        .AW      (AW),
        .CW      (CW),
        .RST_CYC (RST_CYC),
        .TMO     (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_dat    (mem_dat),
        .core_reset (core_reset),
        .core_done  (core_done),
        .busy       (busy),
        .ack        (ack),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_wr   = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            c;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] exp_mem [256];
    logic [7:0] dut_mem [256];
    bit         touched [256];
    logic [7:0] basic_d [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Preload write monitor: each write must match the oldest accepted beat,
    // one cycle after it was accepted
    always @(negedge clk) begin
        wr_t w;
        if (mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(1), 32'(0));
            end else begin
                w = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.a));
                chk("wr_data", 32'(mem_dat), 32'(w.d));
                chk("wr_latency", cyc - w.c, 1);
            end
            dut_mem[mem_addr] = mem_dat;
            n_wr++;
        end
    end

    // One complete run. gap<0: random gaps between beats; done_k<0: never done.
    task automatic do_run(input int nb, input int gap, input int done_k,
                          input bit keep_req, input bit abort10, input bit fixed);
        int  e;
        int  low;
        int  hold;
        int  wr0;
        int  g;
        int  k;
        bit  to;
        bit  seen;
        wr_t w;

        wr0 = n_wr;
        req = 1'b1;
        step();
        chk("load_ready", 32'(ld_ready), 32'(1));
        chk("load_busy", 32'(busy), 32'(1));
        req = keep_req;

        for (int i = 0; i < nb; i++) begin
            if (gap < 0) g = int'($urandom_range(2, 0));
            else         g = (i == 0) ? 0 : gap;
            ld_valid = 1'b0;
            repeat (g) step();
            ld_valid = 1'b1;
            if (fixed) begin
                ld_addr = AW'(i);
                ld_data = basic_d[i];
            end else begin
                ld_addr = AW'($urandom_range(7, 0));
                ld_data = 8'($urandom);
            end
            ld_last = (i == nb - 1);
            w.a = ld_addr;
            w.d = ld_data;
            w.c = cyc;
            exp_q.push_back(w);
            exp_mem[ld_addr] = ld_data;
            touched[ld_addr] = 1'b1;
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        chk("hold_ready", 32'(ld_ready), 32'(0));
        hold = 0;
        while (core_reset === 1'b1 && hold < 20) begin
            hold++;
            ld_valid = 1'($urandom);
            step();
        end
        chk("hold_len", hold, RST_CYC);
        chk("n_writes", n_wr - wr0, nb);

        to = !(done_k >= 0 && done_k <= int'(TMO));
        e  = to ? int'(TMO) : done_k;
        low = 0;
        for (k = 0; k < int'(TMO) + 20; k++) begin
            if (ack === 1'b1) break;
            if (abort10 && k == 10) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                break;
            end
            if (core_reset === 1'b0 && k != done_k) low++;
            core_done = (k == done_k);
            ld_valid  = 1'($urandom);
            step();
        end
        core_done = 1'b0;
        ld_valid  = 1'b0;

        if (abort10) begin
            chk("abort_busy", 32'(busy), 32'(0));
            chk("abort_core_reset", 32'(core_reset), 32'(1));
            chk("abort_cycles", 32'(cycles), 32'(0));
            chk("abort_ready", 32'(ld_ready), 32'(0));
            seen = 1'b0;
            for (int i = 0; i < 5; i++) begin
                if (ack !== 1'b0) seen = 1'b1;
                step();
            end
            chk("abort_no_ack", 32'(seen), 32'(0));
            return;
        end

        chk("ack", 32'(ack), 32'(1));
        chk("cycles", 32'(cycles), e);
        chk("timeout", 32'(timeout), 32'(to));
        chk("rst_low", low, to ? e + 1 : e);
        chk("fin_core_reset", 32'(core_reset), 32'(1));
        step();
        chk("ack_pulse", 32'(ack), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
        chk("cycles_hold", 32'(cycles), e);
        chk("timeout_hold", 32'(timeout), 32'(to));
        if (keep_req) begin
            step();
            chk("b2b_load", 32'(ld_ready), 32'(1));
            chk("b2b_cycles_clr", 32'(cycles), 32'(0));
            chk("b2b_timeout_clr", 32'(timeout), 32'(0));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        basic_d[0] = 8'h12;
        basic_d[1] = 8'h34;
        basic_d[2] = 8'h56;
        for (int i = 0; i < 256; i++) begin
            touched[i] = 1'b0;
            exp_mem[i] = 8'h00;
            dut_mem[i] = 8'h00;
        end
        reset     = 1'b1;
        req       = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_last   = 1'b0;
        core_done = 1'b0;
        repeat (3) step();

        chk("rst_core_reset", 32'(core_reset), 32'(1));
        chk("rst_wr_en", 32'(mem_wr_en), 32'(0));
        chk("rst_ready", 32'(ld_ready), 32'(0));
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_timeout", 32'(timeout), 32'(0));
        chk("rst_cycles", 32'(cycles), 32'(0));

        // Beats offered while idle must be ignored
        reset    = 1'b0;
        ld_valid = 1'b1;
        ld_last  = 1'b1;
        step();
        step();
        chk("idle_ready", 32'(ld_ready), 32'(0));
        chk("idle_busy0", 32'(busy), 32'(0));
        ld_valid = 1'b0;
        ld_last  = 1'b0;

        do_run(3, 0, 40, 1'b0, 1'b0, 1'b1);            // basic run
        do_run(2, 1, 20, 1'b0, 1'b0, 1'b0);            // beats with gaps
        do_run(1, -1, -1, 1'b0, 1'b0, 1'b0);           // timeout
        do_run(2, -1, int'(TMO), 1'b0, 1'b0, 1'b0);    // done exactly at limit
        do_run(3, -1, 25, 1'b0, 1'b1, 1'b0);           // reset mid-run
        do_run(2, -1, 15, 1'b1, 1'b0, 1'b0);           // back-to-back, first
        do_run(3, -1, 30, 1'b0, 1'b0, 1'b0);           // back-to-back, second
        do_run(1, 0, 0, 1'b0, 1'b0, 1'b0);             // done in first run cycle
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(3, 0)) step();
            do_run(int'($urandom_range(6, 1)), -1, int'($urandom_range(60, 0)),
                   1'b0, 1'b0, 1'b0);
        end

        step();
        chk("wr_queue_empty", exp_q.size(), 0);
        for (int a = 0; a < 256; a++) begin
            if (touched[a]) chk("mem_final", 32'(dut_mem[a]), 32'(exp_mem[a]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
